// File: rtl/mu_log2_arbiter.sv
// Round-robin arbiter that shares one ceil-log2 cost unit among NREQ requesters
// and accumulates the returned costs. Build option: MU_ACC_SATURATE_EN (saturating accumulator).
//
// state   | meaning
// IDLE    | choose the next requester round-robin, grant and latch its operand
// COMPUTE | register the bit cost of the latched operand
// RESP    | hold the response until the consumer takes it, then accumulate
module mu_log2_arbiter #(
    parameter int NREQ  = 4,
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_operand,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_id,
    output logic [3:0]          rsp_cost,
    input  logic                acc_clear,
    output logic [ACC_W-1:0]    mu_total,
    output logic                mu_overflow,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t       state;
    logic [2:0]   rr_ptr;
    logic [7:0]   op_q;
    logic         found;
    logic [2:0]   sel;
    int           cand;
    logic [7:0]   op_sel;
    logic         hs;

    // Operands 0..2 cost one bit; above that the cost is the bit length of (x-1).
    function automatic logic [3:0] log2_cost(input logic [7:0] x);
        logic [7:0] m;
        logic [3:0] c;
        m = x - 8'd1;
        c = 4'd1;
        if (x > 8'd2) begin
            for (int i = 0; i < 8; i++) begin
                if (m[i]) c = 4'(i + 1);
            end
        end
        return c;
    endfunction

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = 3'(cand);
            end
        end
    end

    assign op_sel    = req_operand[8*int'(sel) +: 8];
    assign req_ready = (state == IDLE && found && !rst) ? (NREQ'(1) << sel) : '0;
    assign hs        = (state == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_q      <= '0;
            rsp_id    <= '0;
            rsp_cost  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_q   <= op_sel;
                        rsp_id <= sel;
                        busy   <= 1'b1;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    rsp_cost  <= log2_cost(op_q);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= (rsp_id == 3'(NREQ - 1)) ? 3'd0 : rsp_id + 3'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with a handshake empties the accumulator before the add.
    logic [ACC_W-1:0] acc_base;
    logic             ovf_base;
    logic [ACC_W:0]   acc_sum;

    assign acc_base = acc_clear ? '0 : mu_total;
    assign ovf_base = acc_clear ? 1'b0 : mu_overflow;
    assign acc_sum  = {1'b0, acc_base} + {{(ACC_W - 3){1'b0}}, rsp_cost};

    always_ff @(posedge clk) begin
        if (rst) begin
            mu_total    <= '0;
            mu_overflow <= 1'b0;
        end else if (hs) begin
`ifdef MU_ACC_SATURATE_EN
            mu_total    <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
            mu_total    <= acc_sum[ACC_W-1:0];
`endif
            mu_overflow <= ovf_base | acc_sum[ACC_W];
        end else if (acc_clear) begin
            mu_total    <= '0;
            mu_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mu_log2_arbiter.sv
// Directed bench for mu_log2_arbiter: a 32-bit accumulator instance and a 4-bit one
// share stimulus so the overflow behaviour can be observed alongside the main checks.
module tb_mu_log2_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_operand;
    logic              rsp_ready;
    logic              acc_clear;

    logic [NREQ-1:0]   req_ready,   req_ready_b;
    logic              rsp_valid,   rsp_valid_b;
    logic [2:0]        rsp_id,      rsp_id_b;
    logic [3:0]        rsp_cost,    rsp_cost_b;
    logic [31:0]       mu_total;
    logic [3:0]        mu_total_b;
    logic              mu_overflow, mu_overflow_b;
    logic              busy,        busy_b;

    mu_log2_arbiter #(.NREQ(NREQ), .ACC_W(32)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_cost(rsp_cost), .acc_clear(acc_clear),
        .mu_total(mu_total), .mu_overflow(mu_overflow), .busy(busy)
    );

    mu_log2_arbiter #(.NREQ(NREQ), .ACC_W(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_b), .rsp_cost(rsp_cost_b), .acc_clear(acc_clear),
        .mu_total(mu_total_b), .mu_overflow(mu_overflow_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full transaction on requester id; operand is scrambled right after accept.
    task automatic do_req(input int id, input logic [7:0] op, input logic [3:0] exp_cost,
                          input logic clr);
        logic [NREQ-1:0] v;
        int lat;
        v = '0;
        v[id] = 1'b1;
        @(negedge clk);
        req_valid = v;
        req_operand[8*id +: 8] = op;
        #1 check("grant", req_ready, v);
        @(negedge clk);
        req_valid = '0;
        req_operand[8*id +: 8] = ~op;
        check("busy_after_accept", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        check("rsp_id", rsp_id, id);
        check("rsp_cost", rsp_cost, exp_cost);
        check("rsp_cost_b", rsp_cost_b, exp_cost);
        rsp_ready = 1'b1;
        acc_clear = clr;
        @(negedge clk);
        rsp_ready = 1'b0;
        acc_clear = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("busy_after_hs", busy, 0);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [3:0] cost;
    } vec_t;

    vec_t        vt[17];
    int          exp_order[5];
    logic [31:0] run_sum;
    int          ng, last, gidx;
    logic [3:0]  exp_b;

    initial begin
        vt[0]  = '{8'd0,   4'd1};
        vt[1]  = '{8'd1,   4'd1};
        vt[2]  = '{8'd2,   4'd1};
        vt[3]  = '{8'd3,   4'd2};
        vt[4]  = '{8'd4,   4'd2};
        vt[5]  = '{8'd128, 4'd7};
        vt[6]  = '{8'd129, 4'd8};
        vt[7]  = '{8'd255, 4'd8};
        vt[8]  = '{8'd5,   4'd3};
        vt[9]  = '{8'd8,   4'd3};
        vt[10] = '{8'd9,   4'd4};
        vt[11] = '{8'd16,  4'd4};
        vt[12] = '{8'd17,  4'd5};
        vt[13] = '{8'd32,  4'd5};
        vt[14] = '{8'd33,  4'd6};
        vt[15] = '{8'd64,  4'd6};
        vt[16] = '{8'd65,  4'd7};
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_valid = '1;
        req_operand = '0;
        rsp_ready = 1'b0;
        acc_clear = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_cost", rsp_cost, 0);
        check("rst_mu_total", mu_total, 0);
        check("rst_overflow", mu_overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        req_valid = '0;

        // single request
        do_req(0, 8'd5, 4'd3, 1'b0);
        check("single_mu_total", mu_total, 3);

        @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        check("clear_mu_total", mu_total, 0);

        // cost table; the first eight are the boundary operands summing to 30
        run_sum = 0;
        for (int i = 0; i < 17; i++) begin
            do_req(i % NREQ, vt[i].op, vt[i].cost, 1'b0);
            run_sum = run_sum + 32'(vt[i].cost);
            check("table_mu_total", mu_total, run_sum);
        end

        // fairness from reset with everyone requesting
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        ng = 0;
        last = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                gidx = -1;
                for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
                check("fair_id", gidx, exp_order[ng]);
                if (ng > 0) check("fair_gap", c - last, 3);
                last = c;
                ng++;
            end
            @(negedge clk);
        end
        check("fair_count", ng, 5);
        req_valid = '0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        check("fair_drain", busy, 0);
        rsp_ready = 1'b0;

        // backpressure
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        check("bp_clear", mu_total, 0);
        req_operand[8*2 +: 8] = 8'd100;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 8 && !rsp_valid; c++) @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_id", rsp_id, 2);
            check("bp_cost", rsp_cost, 7);
            check("bp_req_ready", req_ready, 0);
            check("bp_mu_hold", mu_total, 0);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_release_add", mu_total, 7);
        @(negedge clk);
        check("bp_single_add", mu_total, 7);

        // overflow on the 4-bit accumulator
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_req(1, 8'd200, 4'd8, 1'b0);
        check("ovf_first_b", mu_total_b, 8);
        check("ovf_first_flag", mu_overflow_b, 0);
        do_req(1, 8'd200, 4'd8, 1'b0);
`ifdef MU_ACC_SATURATE_EN
        exp_b = 4'd15;
`else
        exp_b = 4'd0;
`endif
        check("ovf_second_b", mu_total_b, exp_b);
        check("ovf_second_flag", mu_overflow_b, 1);
        check("ovf_wide_total", mu_total, 16);
        check("ovf_wide_flag", mu_overflow, 0);
        do_req(1, 8'd200, 4'd8, 1'b1);
        check("ovf_clear_add_b", mu_total_b, 8);
        check("ovf_clear_flag", mu_overflow_b, 0);
        check("ovf_clear_add_a", mu_total, 8);

        // reset while a response is pending; rr_ptr would otherwise point at 2
        @(negedge clk);
        req_operand[8*3 +: 8] = 8'd5;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 8 && !rsp_valid; c++) @(negedge clk);
        check("midrsp_valid", rsp_valid, 1);
        req_valid = '1;
        rst = 1'b1;
        #1 check("midrsp_ready_in_rst", req_ready, 0);
        @(negedge clk);
        check("midrsp_rsp_valid", rsp_valid, 0);
        check("midrsp_mu_total", mu_total, 0);
        check("midrsp_busy", busy, 0);
        check("midrsp_rsp_id", rsp_id, 0);
        rst = 1'b0;
        #1 check("midrsp_next_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        check("midrsp_drain", busy, 0);
        rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mu_log2_arbiter.md
# mu_log2_arbiter

Round-robin arbiter and sequencer that shares one ceiling-log2 cost unit (8-bit operand, 4-bit result) among `NREQ` requesters in the Thiele CPU µ-cost path. Each accepted operand is registered, converted to a bit cost, returned on a single response channel tagged with the requester index, and added into a running µ-cost accumulator. The block serialises all log2 cost lookups, so only one cost unit is needed in the datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ACC_W`, 32: µ-cost accumulator width, 4..32.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NREQ  per-requester request pending.
- `req_operand`  in  8*NREQ  requester i operand at bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  3  index of the requester being answered.
- `rsp_cost`  out  4  bit cost of that requester's operand.
- `acc_clear`  in  1  clears `mu_total` and `mu_overflow`.
- `mu_total`  out  ACC_W  accumulated cost.
- `mu_overflow`  out  1  sticky accumulator overflow.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- Cost function, exact:
  - 0→1, 1→1, 2→1.
  - 3..4→2, 5..8→3, 9..16→4, 17..32→5.
  - 33..64→6, 65..128→7, 129..255→8.
- The FSM has three states: IDLE, COMPUTE, RESP.
- IDLE:
  - Select the first `req_valid` at or after `rr_ptr`, wrapping modulo NREQ.
  - Drive `req_ready` one-hot to that requester, combinationally, in the same cycle.
  - On the edge: latch the operand and index, then go to COMPUTE.
  - With no request pending, `req_ready` is 0.
- COMPUTE: register the cost into `rsp_cost`, then go to RESP.
- RESP:
  - Hold `rsp_valid`=1 with `rsp_id` and `rsp_cost` stable until `rsp_ready`=1.
  - On the handshake edge: add the cost to the accumulator, set `rr_ptr` to (winner+1) mod NREQ, go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- Accumulator: `mu_total` + zero-extended 4-bit cost, width ACC_W; the carry-out is the overflow event.
- `acc_clear` is honoured in any state. If it coincides with a response handshake, the clear applies first and then the add, so `mu_total` = that cost and `mu_overflow` = 0.
- `req_operand` is sampled only on the accept edge; later changes do not affect the outstanding response.
- Reset (any state, including mid-RESP):
  - State = IDLE, `rr_ptr`=0, pending response discarded.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_cost`=0, `req_ready`=0 during reset.
  - `mu_total`=0, `mu_overflow`=0, `busy`=0.

## Timing
- Accept edge at cycle N → `rsp_valid` high at cycle N+2 (latency 2).
- Minimum 3 cycles per request (IDLE, COMPUTE, RESP) with `rsp_ready` held high.
- `mu_total` reflects a response on the cycle after its handshake edge.
- `busy` is registered: high from the cycle after accept until the cycle after the handshake.
- `req_ready` depends combinationally on `req_valid`; there is no other combinational input-to-output path.

## Configuration
- `MU_ACC_SATURATE_EN`:
  - Defined: on overflow, `mu_total` clamps to all-ones and `mu_overflow` sets sticky.
  - Undefined: `mu_total` wraps modulo 2^ACC_W and `mu_overflow` still sets sticky.
- In both builds, only `acc_clear` or `rst` clears `mu_overflow`.

## Test plan
- Single request: req 0 operand 5 accepted at cycle N → `rsp_valid` at N+2 with id 0, cost 3; after handshake, `mu_total`=3 and `busy` low one cycle later.
- Fairness: all 4 requesters held valid with `rsp_ready`=1 → grant order 0,1,2,3,0, one grant every 3 cycles.
- Boundaries: operands 0,1,2,3,4,128,129,255 → costs 1,1,1,2,2,7,8,8; `mu_total`=30.
- Backpressure: `rsp_ready` held low 5 cycles in RESP:
  - `rsp_id`/`rsp_cost` stable, `req_ready`=0 throughout, `mu_total` unchanged.
  - A single add occurs on the release.
- Overflow, ACC_W=4, two operands of 200 (cost 8 each):
  - With `MU_ACC_SATURATE_EN`: `mu_total`=15, `mu_overflow`=1.
  - Without it: `mu_total`=0, `mu_overflow`=1.
  - Then pulse `acc_clear` together with a third handshake of cost 8 → `mu_total`=8, `mu_overflow`=0.
- Reset mid-RESP with `rsp_valid`=1 → next cycle `rsp_valid`=0, `mu_total`=0, `rr_ptr`=0; the next grant goes to requester 0 when all are valid.
